// File: rtl/udma_hyper_mem_responder_if.sv
// HyperBus link between the uDMA hyper controller (master) and the memory responder (slave).
// Signal suffixes are from the responder's point of view.
interface udma_hyper_mem_responder_if;
  logic       hyper_cs_ni;
  logic       hyper_ck_i;
  logic       hyper_reset_ni;
  logic [7:0] hyper_dq_i;
  logic [7:0] hyper_dq_o;
  logic       hyper_dq_oe_o;
  logic       hyper_rwds_i;
  logic       hyper_rwds_o;
  logic       hyper_rwds_oe_o;

  modport slave (
    input  hyper_cs_ni, hyper_ck_i, hyper_reset_ni, hyper_dq_i, hyper_rwds_i,
    output hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
  );

  modport master (
    output hyper_cs_ni, hyper_ck_i, hyper_reset_ni, hyper_dq_i, hyper_rwds_i,
    input  hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
  );
endinterface

// File: rtl/udma_hyper_mem_responder.sv
// HyperRAM device-side responder: oversamples the HyperBus on sys_clk_i and serves bursts from
// an internal array plus ID0/CR0. Optional macro HYPER_RESP_VAR_LAT_EN adds refresh_i (1x/2x latency).
module udma_hyper_mem_responder #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 6,
  parameter logic [15:0] ID0_VAL   = 16'h0C81,
  parameter logic [15:0] CR0_RST   = 16'h8F1F
) (
  input  logic                             sys_clk_i,
  input  logic                             rst_i,
`ifdef HYPER_RESP_VAR_LAT_EN
  input  logic                             refresh_i,
`endif
  udma_hyper_mem_responder_if.slave        hyper,
  output logic                             busy_o
);
  localparam int unsigned WORDS     = MEM_BYTES / 2;
  localparam int unsigned AW        = $clog2(WORDS);
  localparam logic [5:0]  LAT_LONG  = 6'(4 * LATENCY);
  localparam logic [5:0]  LAT_SHORT = 6'(2 * LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CA, ST_LAT, ST_RD, ST_WR, ST_REGWR, ST_WAIT_CS
  } state_t;

  state_t         state_q;
  logic           dev_rst;
  logic           cs_q, cs_qq, ck_q, ck_qq, rwds_q, rwds_qq;
  logic [7:0]     dq_q, dq_qq;
  logic           beat, cs_fall, cs_rise;
  logic [39:0]    ca_q;
  logic [47:0]    ca_next;
  logic [31:0]    ca_addr;
  logic           ca_unused;
  logic [5:0]     cnt_q;
  logic           half_q;
  logic [AW-1:0]  addr_q;
  logic           is_rd_q, is_reg_q, lin_q, long_lat_q;
  logic           reg_id0_q, reg_cr0_q;
  logic [7:0]     regwr_hi_q;
  logic [15:0]    cr0_q;
  logic [15:0]    reg_word;
  logic [15:0]    mem_rd_word;
  logic [7:0]     rd_hi, rd_lo;
  logic [1:0]     lane_we;
  logic           refresh_sel;
  logic [7:0]     dq_o_q;
  logic           dq_oe_q, rwds_o_q, rwds_oe_q;

  // The device reset pin behaves like rst_i but never touches the array.
  assign dev_rst = rst_i | ~hyper.hyper_reset_ni;

`ifdef HYPER_RESP_VAR_LAT_EN
  assign refresh_sel = refresh_i;
`else
  assign refresh_sel = 1'b1;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (dev_rst) begin
      cs_q    <= 1'b1;
      cs_qq   <= 1'b1;
      ck_q    <= 1'b0;
      ck_qq   <= 1'b0;
      rwds_q  <= 1'b0;
      rwds_qq <= 1'b0;
      dq_q    <= '0;
      dq_qq   <= '0;
    end else begin
      cs_q    <= hyper.hyper_cs_ni;
      cs_qq   <= cs_q;
      ck_q    <= hyper.hyper_ck_i;
      ck_qq   <= ck_q;
      rwds_q  <= hyper.hyper_rwds_i;
      rwds_qq <= rwds_q;
      dq_q    <= hyper.hyper_dq_i;
      dq_qq   <= dq_q;
    end
  end

  assign beat      = ck_q ^ ck_qq;
  assign cs_fall   = cs_qq & ~cs_q;
  assign cs_rise   = ~cs_qq & cs_q;
  assign ca_next   = {ca_q, dq_qq};
  assign ca_addr   = {ca_next[44:16], ca_next[2:0]};
  assign ca_unused = ^ca_next[15:3];

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a, input logic lin);
    if (lin) return a + 1'b1;
    return {a[AW-1:4], a[3:0] + 4'd1};
  endfunction

  assign reg_word = reg_id0_q ? ID0_VAL : (reg_cr0_q ? cr0_q : 16'h0000);
  assign rd_hi    = is_reg_q ? reg_word[15:8] : mem_rd_word[15:8];
  assign rd_lo    = is_reg_q ? reg_word[7:0]  : mem_rd_word[7:0];

  always_comb begin
    lane_we = '0;
    if (!dev_rst && !cs_rise && beat && state_q == ST_WR && !rwds_qq) begin
      if (half_q) lane_we[0] = 1'b1;
      else        lane_we[1] = 1'b1;
    end
  end

  // Lane 1 holds the upper byte of each word, lane 0 the lower byte.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge sys_clk_i) begin
      if (lane_we[gi]) mem[addr_q] <= dq_qq;
      rd_q <= mem[addr_q];
    end
    assign mem_rd_word[gi*8 +: 8] = rd_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (dev_rst) begin
      state_q    <= ST_IDLE;
      ca_q       <= '0;
      cnt_q      <= '0;
      half_q     <= 1'b0;
      addr_q     <= '0;
      is_rd_q    <= 1'b0;
      is_reg_q   <= 1'b0;
      lin_q      <= 1'b0;
      long_lat_q <= 1'b1;
      reg_id0_q  <= 1'b0;
      reg_cr0_q  <= 1'b0;
      regwr_hi_q <= '0;
      cr0_q      <= CR0_RST;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      rwds_o_q   <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else if (cs_rise) begin
      // CS release overrides any beat seen in the same cycle.
      state_q   <= ST_IDLE;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q    <= ST_CA;
            cnt_q      <= '0;
            rwds_oe_q  <= 1'b1;
            rwds_o_q   <= refresh_sel;
            long_lat_q <= refresh_sel;
          end
        end
        ST_CA: begin
          if (beat) begin
            ca_q  <= ca_next[39:0];
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd5) begin
              is_rd_q   <= ca_next[47];
              is_reg_q  <= ca_next[46];
              lin_q     <= ca_next[45];
              addr_q    <= ca_addr[AW-1:0];
              reg_id0_q <= (ca_addr == 32'h0000_0000);
              reg_cr0_q <= (ca_addr == 32'h0000_0800);
              half_q    <= 1'b0;
              rwds_o_q  <= 1'b0;
              rwds_oe_q <= ca_next[47];
              if (ca_next[46] && !ca_next[47]) begin
                state_q <= ST_REGWR;
              end else begin
                state_q <= ST_LAT;
                cnt_q   <= long_lat_q ? LAT_LONG : LAT_SHORT;
              end
            end
          end
        end
        ST_LAT: begin
          if (beat) begin
            if (cnt_q == 6'd1) begin
              half_q <= 1'b0;
              if (is_rd_q) begin
                state_q  <= ST_RD;
                dq_oe_q  <= 1'b1;
                dq_o_q   <= rd_hi;
                rwds_o_q <= 1'b1;
              end else begin
                state_q <= ST_WR;
              end
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        ST_RD: begin
          // The address moves on after the upper byte so the array read is ready for the next word.
          if (beat) begin
            half_q <= ~half_q;
            if (!half_q) begin
              dq_o_q    <= rd_lo;
              rwds_o_q  <= 1'b0;
              addr_q    <= addr_inc(addr_q, lin_q);
              reg_id0_q <= 1'b0;
              reg_cr0_q <= 1'b0;
            end else begin
              dq_o_q   <= rd_hi;
              rwds_o_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (beat) begin
            half_q <= ~half_q;
            if (half_q) addr_q <= addr_inc(addr_q, lin_q);
          end
        end
        ST_REGWR: begin
          if (beat) begin
            half_q <= ~half_q;
            if (!half_q) begin
              regwr_hi_q <= dq_qq;
            end else begin
              if (reg_cr0_q) cr0_q <= {regwr_hi_q, dq_qq};
              state_q <= ST_WAIT_CS;
            end
          end
        end
        ST_WAIT_CS: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hyper.hyper_dq_o      = dq_o_q;
  assign hyper.hyper_dq_oe_o   = dq_oe_q;
  assign hyper.hyper_rwds_o    = rwds_o_q;
  assign hyper.hyper_rwds_oe_o = rwds_oe_q;
  assign busy_o                = (state_q != ST_IDLE);
endmodule

// File: tb/tb_udma_hyper_mem_responder.sv
// Directed bench for udma_hyper_mem_responder: a table of HyperBus transactions with
// hand-computed results, plus hand-written abort / reset / CS-vs-beat sequences.
module tb_udma_hyper_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic refresh = 1'b1;

  always #5 clk = ~clk;

  udma_hyper_mem_responder_if bus ();

  udma_hyper_mem_responder #(
    .MEM_BYTES(1024),
    .LATENCY  (6),
    .ID0_VAL  (16'h0C81),
    .CR0_RST  (16'h8F1F)
  ) dut (
    .sys_clk_i(clk),
    .rst_i    (rst),
`ifdef HYPER_RESP_VAR_LAT_EN
    .refresh_i(refresh),
`endif
    .hyper    (bus),
    .busy_o   (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  smp_dq;
  logic        smp_rwds, smp_oe, smp_rwds_oe;
  logic [15:0] rd_w  [4];
  logic [1:0]  rd_rw [4];

  typedef struct {
    logic        rw;
    logic        areg;
    logic        lin;
    logic [31:0] addr;
    int          n;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CK edge; the responder's outputs are sampled just before the edge, as the host would.
  task automatic beat(input logic [7:0] d, input logic m);
    bus.hyper_dq_i   = d;
    bus.hyper_rwds_i = m;
    cyc(1);
    smp_dq      = bus.hyper_dq_o;
    smp_rwds    = bus.hyper_rwds_o;
    smp_oe      = bus.hyper_dq_oe_o;
    smp_rwds_oe = bus.hyper_rwds_oe_o;
    bus.hyper_ck_i = ~bus.hyper_ck_i;
    cyc(3);
  endtask

  task automatic send_ca(input logic rw, input logic areg, input logic lin, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rw, areg, lin, a[31:3], 13'd0, a[2:0]};
    bus.hyper_cs_ni = 1'b0;
    cyc(4);
    check("ca_rwds_oe", bus.hyper_rwds_oe_o, 1);
    check("ca_rwds", bus.hyper_rwds_o, 1);
    for (int i = 0; i < 6; i++) beat(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic send_lat(input logic rw);
    for (int i = 0; i < 24; i++) beat(8'h00, 1'b0);
    check("lat_last_dq_oe", smp_oe, 0);
    check("lat_rwds_oe", smp_rwds_oe, rw);
  endtask

  task automatic end_txn();
    bus.hyper_cs_ni = 1'b1;
    cyc(2);
    check("end_busy", busy, 0);
    check("end_dq_oe", bus.hyper_dq_oe_o, 0);
    check("end_rwds_oe", bus.hyper_rwds_oe_o, 0);
    cyc(2);
  endtask

  task automatic txn(input logic rw, input logic areg, input logic lin, input logic [31:0] a,
                     input int n, input logic [63:0] wd, input logic [7:0] wm);
    send_ca(rw, areg, lin, a);
    if (!(areg && !rw)) send_lat(rw);
    for (int w = 0; w < n; w++) begin
      beat(wd[63-16*w -: 8], wm[7-2*w]);
      if (w == 0 && rw) check("first_dq_oe", smp_oe, 1);
      rd_w[w][15:8] = smp_dq;
      rd_rw[w][1]   = smp_rwds;
      beat(wd[55-16*w -: 8], wm[6-2*w]);
      rd_w[w][7:0]  = smp_dq;
      rd_rw[w][0]   = smp_rwds;
    end
    end_txn();
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h800, 1, 64'h0, 8'h00, 64'h8F1F_0000_0000_0000};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 32'h010, 4, 64'h1111_2222_3333_4444, 8'h00, 64'h0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 32'h010, 4, 64'h0, 8'h00, 64'h1111_2222_3333_4444};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h020, 1, 64'hAAAA_0000_0000_0000, 8'h00, 64'h0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 32'h020, 1, 64'h5555_0000_0000_0000, 8'h80, 64'h0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 32'h020, 1, 64'h0, 8'h00, 64'hAA55_0000_0000_0000};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h01E, 2, 64'h1E1E_1F1F_0000_0000, 8'h00, 64'h0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h01E, 4, 64'h0, 8'h00, 64'h1E1E_1F1F_1111_2222};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 32'h800, 1, 64'h8F17_0000_0000_0000, 8'h00, 64'h0};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h000, 1, 64'h0, 8'h00, 64'h0C81_0000_0000_0000};
    vt[10] = '{1'b1, 1'b1, 1'b1, 32'h800, 1, 64'h0, 8'h00, 64'h8F17_0000_0000_0000};
    vt[11] = '{1'b0, 1'b1, 1'b1, 32'h000, 1, 64'h1234_0000_0000_0000, 8'h00, 64'h0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 32'h800, 1, 64'h0, 8'h00, 64'h8F17_0000_0000_0000};
    vt[13] = '{1'b1, 1'b1, 1'b1, 32'h000, 1, 64'h0, 8'h00, 64'h0C81_0000_0000_0000};
    vt[14] = '{1'b0, 1'b0, 1'b1, 32'h1FF, 2, 64'hABCD_EF01_0000_0000, 8'h00, 64'h0};
    vt[15] = '{1'b1, 1'b0, 1'b1, 32'h000, 1, 64'h0, 8'h00, 64'hEF01_0000_0000_0000};
    vt[16] = '{1'b1, 1'b0, 1'b1, 32'h1FF, 2, 64'h0, 8'h00, 64'hABCD_EF01_0000_0000};
    vt[17] = '{1'b1, 1'b1, 1'b1, 32'h001, 1, 64'h0, 8'h00, 64'h0000_0000_0000_0000};

    bus.hyper_cs_ni    = 1'b1;
    bus.hyper_ck_i     = 1'b0;
    bus.hyper_reset_ni = 1'b1;
    bus.hyper_dq_i     = 8'h00;
    bus.hyper_rwds_i   = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("rst_dq_o", bus.hyper_dq_o, 0);
    check("rst_dq_oe", bus.hyper_dq_oe_o, 0);
    check("rst_rwds_o", bus.hyper_rwds_o, 0);
    check("rst_rwds_oe", bus.hyper_rwds_oe_o, 0);
    check("rst_busy", busy, 0);
    $display("txn reset: outputs idle");

    for (int v = 0; v < 18; v++) begin
      txn(vt[v].rw, vt[v].areg, vt[v].lin, vt[v].addr, vt[v].n, vt[v].wd, vt[v].wm);
      if (vt[v].rw) begin
        for (int w = 0; w < vt[v].n; w++) begin
          check($sformatf("v%0d_word%0d", v, w), rd_w[w], vt[v].exp[63-16*w -: 16]);
          check($sformatf("v%0d_rwds%0d", v, w), rd_rw[w], 2'b10);
        end
      end
      $display("txn %0d: %s %s lin=%0d addr=%h words=%0d", v, vt[v].rw ? "read " : "write",
               vt[v].areg ? "reg" : "mem", vt[v].lin, vt[v].addr, vt[v].n);
    end

    // Read aborted after three data bytes, then a normal read must decode cleanly.
    send_ca(1'b1, 1'b0, 1'b1, 32'h010);
    send_lat(1'b1);
    beat(8'h00, 1'b0);
    check("abort_b0", smp_dq, 8'h11);
    beat(8'h00, 1'b0);
    check("abort_b1", smp_dq, 8'h11);
    beat(8'h00, 1'b0);
    check("abort_b2", smp_dq, 8'h22);
    end_txn();
    txn(1'b1, 1'b0, 1'b1, 32'h011, 1, 64'h0, 8'h00);
    check("after_abort_word", rd_w[0], 16'h2222);
    $display("txn abort: read cut after 3 bytes, follow-up read of 0x011");

    // CS release in the same cycle as the lower-byte beat: only the upper byte lands.
    txn(1'b0, 1'b0, 1'b1, 32'h030, 1, 64'hBEEF_0000_0000_0000, 8'h00);
    send_ca(1'b0, 1'b0, 1'b1, 32'h030);
    send_lat(1'b0);
    beat(8'h12, 1'b0);
    bus.hyper_dq_i = 8'h34;
    cyc(1);
    bus.hyper_ck_i  = ~bus.hyper_ck_i;
    bus.hyper_cs_ni = 1'b1;
    cyc(2);
    check("csbeat_busy", busy, 0);
    cyc(2);
    txn(1'b1, 1'b0, 1'b1, 32'h030, 1, 64'h0, 8'h00);
    check("csbeat_word", rd_w[0], 16'h12EF);
    $display("txn cs_vs_beat: word 0x030 after half write");

    // Device reset pin: CR0 returns to its reset value, array contents survive.
    bus.hyper_reset_ni = 1'b0;
    cyc(2);
    bus.hyper_reset_ni = 1'b1;
    cyc(2);
    check("hrst_busy", busy, 0);
    check("hrst_rwds_oe", bus.hyper_rwds_oe_o, 0);
    txn(1'b1, 1'b1, 1'b1, 32'h800, 1, 64'h0, 8'h00);
    check("hrst_cr0", rd_w[0], 16'h8F1F);
    txn(1'b1, 1'b0, 1'b1, 32'h010, 2, 64'h0, 8'h00);
    check("hrst_mem0", rd_w[0], 16'h1111);
    check("hrst_mem1", rd_w[1], 16'h2222);
    $display("txn hyper_reset: CR0 and array after reset pulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
